// File: rtl/my_fifo_pkg.sv
// -----------------------------------------------------------------------------
// my_fifo_pkg
// Constants, types and elaboration-time helpers shared by the synchronous
// FIFO (my_param_sync_fifo) and its storage array (my_fifo_ram).
//   addr_width()     : address bits needed to index DEPTH entries
//   def_af_thresh()  : default almost_full level (two entries below full)
//   DEF_AE_THRESH    : default almost_empty level
//   fifo_status_t    : bundled occupancy flags derived from the count
// -----------------------------------------------------------------------------
package my_fifo_pkg;

   localparam int unsigned DEF_WIDTH     = 8;
   localparam int unsigned DEF_DEPTH     = 8;
   localparam int unsigned DEF_AE_THRESH = 2;

   // Address bits for a power-of-two depth; never less than one bit.
   function automatic int unsigned addr_width(input int unsigned depth);
      return (depth <= 1) ? 1 : $clog2(depth);
   endfunction

   // Default almost_full level: two entries short of full.
   function automatic int unsigned def_af_thresh(input int unsigned depth);
      return (depth > 2) ? depth - 2 : 1;
   endfunction

   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      logic almost_empty;
   } fifo_status_t;

endpackage : my_fifo_pkg

// File: rtl/my_fifo_ram.sv
// -----------------------------------------------------------------------------
// my_fifo_ram
// Simple dual-port storage array: one synchronous write port and one
// registered read port with enable. No reset on the array or the read
// register, so the array maps onto plain block/distributed RAM.
// Ports:
//   clk_i    : clock, all activity on rising edge
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   re_i     : read enable; rdata_o loads mem[raddr_i] when high, holds otherwise
//   raddr_i  : read address
//   rdata_o  : registered read data
// -----------------------------------------------------------------------------
module my_fifo_ram
   import my_fifo_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned DEPTH = DEF_DEPTH,
   parameter int unsigned AW    = addr_width(DEPTH)
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             re_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule : my_fifo_ram

// File: rtl/my_param_sync_fifo.sv
// -----------------------------------------------------------------------------
// my_param_sync_fifo
// Single-clock FIFO with registered read data (1-cycle read latency),
// occupancy count, threshold flags and sticky overflow/underflow flags.
// Parameters: WIDTH (data bits), DEPTH (entries, power of 2, >=2),
//             AF_THRESH (almost_full at count >= level),
//             AE_THRESH (almost_empty at count <= level).
// Ports:
//   clk          : clock, all state updates on rising edge
//   nrst         : asynchronous active-low reset
//   w_en, w_data : write request and data (accepted when not full)
//   r_en         : read request (accepted when not empty)
//   clr_err      : synchronous clear of overflow/underflow
//   r_data       : read data, updated one cycle after an accepted read
//   r_valid      : high for the cycle r_data was updated by an accepted read
//   full, empty, almost_full, almost_empty : occupancy flags
//   count        : occupancy 0..DEPTH
//   overflow     : sticky, set by a write attempt while full
//   underflow    : sticky, set by a read attempt while empty
// -----------------------------------------------------------------------------
module my_param_sync_fifo
   import my_fifo_pkg::*;
#(
   parameter int unsigned WIDTH     = DEF_WIDTH,
   parameter int unsigned DEPTH     = DEF_DEPTH,
   parameter int unsigned AF_THRESH = def_af_thresh(DEPTH),
   parameter int unsigned AE_THRESH = DEF_AE_THRESH
) (
   input  logic                      clk,
   input  logic                      nrst,
   input  logic                      w_en,
   input  logic [WIDTH-1:0]          w_data,
   input  logic                      r_en,
   input  logic                      clr_err,
   output logic [WIDTH-1:0]          r_data,
   output logic                      r_valid,
   output logic                      full,
   output logic                      empty,
   output logic                      almost_full,
   output logic                      almost_empty,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      overflow,
   output logic                      underflow
);

   localparam int unsigned AW = addr_width(DEPTH);
   localparam int unsigned CW = AW + 1;

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
   localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
   localparam logic [CW-1:0] ONE_C   = CW'(1);

   // Pointers carry one wrap bit above the address bits.
   logic [CW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_s;
   logic             r_valid_q;
   logic             rd_seen_q, rd_seen_d;
   logic             ovf_q, ovf_d;
   logic             udf_q, udf_d;
   logic             wr_acc, rd_acc;
   logic [WIDTH-1:0] ram_rdata;
   fifo_status_t     status;

   // Occupancy is the modular pointer distance; the wrap bit makes
   // DEPTH distinguishable from 0, so no separate count register is kept.
   assign count_s = wr_ptr_q - rd_ptr_q;

   always_comb begin
      status              = '0;
      status.full         = (count_s == DEPTH_C);
      status.empty        = (count_s == '0);
      status.almost_full  = (count_s >= AF_C);
      status.almost_empty = (count_s <= AE_C);
   end

   // Acceptance uses only this cycle's registered state, so a read
   // never frees space for a same-cycle write (and vice versa).
   assign wr_acc = w_en & ~status.full;
   assign rd_acc = r_en & ~status.empty;

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      rd_seen_d = rd_seen_q | rd_acc;
      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + ONE_C;
      end
      if (rd_acc) begin
         rd_ptr_d = rd_ptr_q + ONE_C;
      end
      // A new error event takes priority over a simultaneous clear.
      ovf_d = (w_en & status.full)  | (ovf_q & ~clr_err);
      udf_d = (r_en & status.empty) | (udf_q & ~clr_err);
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         r_valid_q <= 1'b0;
         rd_seen_q <= 1'b0;
         ovf_q     <= 1'b0;
         udf_q     <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         r_valid_q <= rd_acc;
         rd_seen_q <= rd_seen_d;
         ovf_q     <= ovf_d;
         udf_q     <= udf_d;
      end
   end

   my_fifo_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk_i   (clk),
      .we_i    (wr_acc),
      .waddr_i (wr_ptr_q[AW-1:0]),
      .wdata_i (w_data),
      .re_i    (rd_acc),
      .raddr_i (rd_ptr_q[AW-1:0]),
      .rdata_o (ram_rdata)
   );

   // The RAM read register has no reset; rd_seen_q gates it to zero from
   // reset until the first accepted read, keeping the 1-cycle latency.
   assign r_data       = rd_seen_q ? ram_rdata : '0;
   assign r_valid      = r_valid_q;
   assign full         = status.full;
   assign empty        = status.empty;
   assign almost_full  = status.almost_full;
   assign almost_empty = status.almost_empty;
   assign count        = count_s;
   assign overflow     = ovf_q;
   assign underflow    = udf_q;

endmodule : my_param_sync_fifo

// File: tb/tb_my_param_sync_fifo.sv
module tb_my_param_sync_fifo;

   logic       clk;
   logic       nrst;
   logic       w_en;
   logic [7:0] w_data;
   logic       r_en;
   logic       clr_err;
   logic [7:0] r_data;
   logic       r_valid;
   logic       full;
   logic       empty;
   logic       almost_full;
   logic       almost_empty;
   logic [3:0] count;
   logic       overflow;
   logic       underflow;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: queue of stored words plus expected output registers.
   logic [7:0] q[$];
   logic       m_ovf;
   logic       m_udf;
   logic       m_rvalid;
   logic [7:0] m_rdata;

   my_param_sync_fifo #(
      .WIDTH     (8),
      .DEPTH     (8),
      .AF_THRESH (6),
      .AE_THRESH (2)
   ) dut (
      .clk          (clk),
      .nrst         (nrst),
      .w_en         (w_en),
      .w_data       (w_data),
      .r_en         (r_en),
      .clr_err      (clr_err),
      .r_data       (r_data),
      .r_valid      (r_valid),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      q.delete();
      m_ovf    = 1'b0;
      m_udf    = 1'b0;
      m_rvalid = 1'b0;
      m_rdata  = 8'h00;
   endtask

   // Drive one cycle of requests, advance past the edge, update the model.
   task automatic do_cycle(input logic w, input logic [7:0] d, input logic r, input logic c);
      bit fm, em, wa, ra;
      fm = (q.size() == 8);
      em = (q.size() == 0);
      wa = w && !fm;
      ra = r && !em;
      w_en    = w;
      w_data  = d;
      r_en    = r;
      clr_err = c;
      @(posedge clk);
      #1;
      m_rvalid = ra;
      if (ra) m_rdata = q.pop_front();
      if (wa) q.push_back(d);
      m_ovf = (w && fm) || (m_ovf && !c);
      m_udf = (r && em) || (m_udf && !c);
      w_en    = 1'b0;
      r_en    = 1'b0;
      clr_err = 1'b0;
   endtask

   task automatic test_reset();
      nrst = 1'b1;
      w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0; w_data = 8'h00;
      #3 nrst = 1'b0;
      #1;
      model_reset();
      n_checks++; if (count !== 4'd0) $display("FAIL reset_count got=%0d exp=0", count); else n_pass++;
      n_checks++; if ({empty, full, almost_empty, almost_full} !== 4'b1010)
         $display("FAIL reset_flags got=%b exp=1010 (empty,full,ae,af)", {empty, full, almost_empty, almost_full}); else n_pass++;
      n_checks++; if ({r_valid, overflow, underflow} !== 3'b000)
         $display("FAIL reset_rv_err got=%b exp=000", {r_valid, overflow, underflow}); else n_pass++;
      n_checks++; if (r_data !== 8'h00) $display("FAIL reset_rdata got=%h exp=00", r_data); else n_pass++;
      #4 nrst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_fill_drain();
      for (int i = 1; i <= 8; i++) begin
         do_cycle(1'b1, 8'(i), 1'b0, 1'b0);
         n_checks++; if (count !== 4'(i)) $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, count, i); else n_pass++;
         n_checks++; if (almost_full !== (i >= 6)) $display("FAIL fill_af i=%0d got=%b exp=%b", i, almost_full, (i >= 6)); else n_pass++;
         n_checks++; if (full !== (i == 8)) $display("FAIL fill_full i=%0d got=%b exp=%b", i, full, (i == 8)); else n_pass++;
         n_checks++; if (r_valid !== 1'b0) $display("FAIL fill_rvalid i=%0d got=%b exp=0", i, r_valid); else n_pass++;
      end
      for (int i = 1; i <= 8; i++) begin
         do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
         n_checks++; if (r_valid !== 1'b1) $display("FAIL drain_rvalid i=%0d got=%b exp=1", i, r_valid); else n_pass++;
         n_checks++; if (r_data !== 8'(i)) $display("FAIL drain_rdata i=%0d got=%h exp=%h", i, r_data, 8'(i)); else n_pass++;
         n_checks++; if (almost_empty !== ((8 - i) <= 2)) $display("FAIL drain_ae i=%0d got=%b exp=%b", i, almost_empty, ((8 - i) <= 2)); else n_pass++;
      end
      n_checks++; if (empty !== 1'b1) $display("FAIL drain_empty got=%b exp=1", empty); else n_pass++;
      do_cycle(1'b0, 8'h00, 1'b0, 1'b0);
      n_checks++; if (r_valid !== 1'b0 || r_data !== 8'h08)
         $display("FAIL idle_hold got=%b/%h exp=0/08", r_valid, r_data); else n_pass++;
   endtask

   task automatic test_full_rw();
      for (int i = 0; i < 8; i++) do_cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
      n_checks++; if (full !== 1'b1) $display("FAIL frw_full got=%b exp=1", full); else n_pass++;
      do_cycle(1'b1, 8'hEE, 1'b1, 1'b0);
      n_checks++; if (count !== 4'd7) $display("FAIL frw_count got=%0d exp=7", count); else n_pass++;
      n_checks++; if (overflow !== 1'b1) $display("FAIL frw_ovf got=%b exp=1", overflow); else n_pass++;
      n_checks++; if (r_valid !== 1'b1 || r_data !== m_rdata)
         $display("FAIL frw_read got=%b/%h exp=1/%h", r_valid, r_data, m_rdata); else n_pass++;
      do_cycle(1'b0, 8'h00, 1'b0, 1'b1);
      n_checks++; if (overflow !== 1'b0) $display("FAIL frw_clr got=%b exp=0", overflow); else n_pass++;
      while (q.size() > 0) begin
         do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
         n_checks++; if (r_data !== m_rdata) $display("FAIL frw_drain got=%h exp=%h", r_data, m_rdata); else n_pass++;
      end
   endtask

   task automatic test_empty_rw();
      do_cycle(1'b1, 8'h3C, 1'b1, 1'b0);
      n_checks++; if (count !== 4'd1) $display("FAIL erw_count got=%0d exp=1", count); else n_pass++;
      n_checks++; if (underflow !== 1'b1) $display("FAIL erw_udf got=%b exp=1", underflow); else n_pass++;
      n_checks++; if (r_valid !== 1'b0) $display("FAIL erw_rvalid got=%b exp=0", r_valid); else n_pass++;
      do_cycle(1'b0, 8'h00, 1'b1, 1'b1);
      n_checks++; if (r_valid !== 1'b1 || r_data !== 8'h3C)
         $display("FAIL erw_read got=%b/%h exp=1/3c", r_valid, r_data); else n_pass++;
      n_checks++; if (underflow !== 1'b0) $display("FAIL erw_clr got=%b exp=0", underflow); else n_pass++;
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 4; i++) do_cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         do_cycle(1'b1, 8'($urandom), 1'b1, 1'b0);
         n_checks++; if (count !== 4'd4) $display("FAIL wrap_count i=%0d got=%0d exp=4", i, count); else n_pass++;
         n_checks++; if (r_valid !== 1'b1 || r_data !== m_rdata)
            $display("FAIL wrap_data i=%0d got=%b/%h exp=1/%h", i, r_valid, r_data, m_rdata); else n_pass++;
      end
      while (q.size() > 0) begin
         do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
         n_checks++; if (r_data !== m_rdata) $display("FAIL wrap_drain got=%h exp=%h", r_data, m_rdata); else n_pass++;
      end
   endtask

   task automatic test_clr_err();
      for (int i = 0; i < 8; i++) do_cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
      do_cycle(1'b1, 8'h11, 1'b0, 1'b0);
      n_checks++; if (overflow !== 1'b1) $display("FAIL clr_set got=%b exp=1", overflow); else n_pass++;
      do_cycle(1'b0, 8'h00, 1'b0, 1'b1);
      n_checks++; if (overflow !== 1'b0) $display("FAIL clr_pulse got=%b exp=0", overflow); else n_pass++;
      do_cycle(1'b1, 8'h22, 1'b0, 1'b1);
      n_checks++; if (overflow !== 1'b1) $display("FAIL clr_setwins got=%b exp=1", overflow); else n_pass++;
      do_cycle(1'b0, 8'h00, 1'b0, 1'b0);
      n_checks++; if (overflow !== 1'b1) $display("FAIL clr_sticky got=%b exp=1", overflow); else n_pass++;
      n_checks++; if (count !== 4'd8) $display("FAIL clr_count got=%0d exp=8", count); else n_pass++;
      do_cycle(1'b0, 8'h00, 1'b0, 1'b1);
      while (q.size() > 0) begin
         do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
         n_checks++; if (r_data !== m_rdata) $display("FAIL clr_drain got=%h exp=%h", r_data, m_rdata); else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) do_cycle(1'b1, 8'h90 + 8'(i), 1'b0, 1'b0);
      do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
      do_cycle(1'b1, 8'h95, 1'b0, 1'b0);
      n_checks++; if (count !== 4'd5) $display("FAIL rmid_pre got=%0d exp=5", count); else n_pass++;
      w_en = 1'b1; w_data = 8'h77;
      #3 nrst = 1'b0;
      #1;
      n_checks++; if (count !== 4'd0) $display("FAIL rmid_count got=%0d exp=0", count); else n_pass++;
      n_checks++; if (empty !== 1'b1) $display("FAIL rmid_empty got=%b exp=1", empty); else n_pass++;
      n_checks++; if (r_data !== 8'h00) $display("FAIL rmid_rdata got=%h exp=00", r_data); else n_pass++;
      w_en = 1'b0;
      model_reset();
      @(posedge clk);
      #1 nrst = 1'b1;
      do_cycle(1'b1, 8'h5A, 1'b0, 1'b0);
      do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
      n_checks++; if (r_valid !== 1'b1 || r_data !== 8'h5A)
         $display("FAIL rmid_new got=%b/%h exp=1/5a", r_valid, r_data); else n_pass++;
      n_checks++; if (empty !== 1'b1 || underflow !== 1'b0)
         $display("FAIL rmid_end got=%b/%b exp=1/0", empty, underflow); else n_pass++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         int unsigned wp, rp;
         wp = (i < 130) ? 75 : (i < 260) ? 30 : 55;
         rp = (i < 130) ? 30 : (i < 260) ? 75 : 55;
         do_cycle(($urandom_range(99) < wp), 8'($urandom), ($urandom_range(99) < rp), ($urandom_range(15) == 0));
         n_checks++; if (count !== 4'(q.size())) $display("FAIL rnd_count i=%0d got=%0d exp=%0d", i, count, q.size()); else n_pass++;
         n_checks++; if ({full, empty, almost_full, almost_empty} !==
                         {q.size() == 8, q.size() == 0, q.size() >= 6, q.size() <= 2})
            $display("FAIL rnd_flags i=%0d got=%b exp=%b", i, {full, empty, almost_full, almost_empty},
                     {q.size() == 8, q.size() == 0, q.size() >= 6, q.size() <= 2}); else n_pass++;
         n_checks++; if (r_valid !== m_rvalid || r_data !== m_rdata)
            $display("FAIL rnd_read i=%0d got=%b/%h exp=%b/%h", i, r_valid, r_data, m_rvalid, m_rdata); else n_pass++;
         n_checks++; if ({overflow, underflow} !== {m_ovf, m_udf})
            $display("FAIL rnd_err i=%0d got=%b exp=%b", i, {overflow, underflow}, {m_ovf, m_udf}); else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_full_rw();
      test_empty_rw();
      test_wrap();
      test_clr_err();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_my_param_sync_fifo

// File: doc/my_param_sync_fifo.md
MY_PARAM_SYNC_FIFO -- requirements
Module: my_param_sync_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 8, entry count; power of 2, >=2.
REQ-003 SHALL have parameter AF_THRESH, default DEPTH-2, almost_full level in entries (1..DEPTH).
REQ-004 SHALL have parameter AE_THRESH, default 2, almost_empty level in entries (0..DEPTH-1).
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port nrst  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port w_en  input  1  write request.
REQ-008 SHALL have port w_data  input  WIDTH  write data.
REQ-009 SHALL have port r_en  input  1  read request.
REQ-010 SHALL have port clr_err  input  1  synchronous clear of sticky error flags.
REQ-011 SHALL have port r_data  output  WIDTH  registered read data.
REQ-012 SHALL have port r_valid  output  1  high one cycle when r_data updated by an accepted read.
REQ-013 SHALL have port full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-015 SHALL have port overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 SHALL accept a write when w_en=1 and full=0; data stored at wr_ptr, wr_ptr increments.
REQ-017 SHALL accept a read when r_en=1 and empty=0; r_data <= mem[rd_ptr] at that edge, rd_ptr increments, r_valid=1 next cycle; read latency exactly 1 cycle.
REQ-018 SHALL hold r_data unchanged and drive r_valid=0 in cycles without an accepted read.
REQ-019 SHALL use pointers of $clog2(DEPTH)+1 bits; low bits address, MSB wrap bit; wrap from DEPTH-1 to 0 seamless.
REQ-020 SHALL compute full/empty/thresholds from registered state of the current cycle only: write on full rejected even with simultaneous read; read on empty rejected even with simultaneous write.
REQ-021 SHALL, on simultaneous accepted read and write, leave count unchanged and advance both pointers.
REQ-022 SHALL update count +1 on write-only, -1 on read-only accept.
REQ-023 SHALL drive empty = (count==0), full = (count==DEPTH), almost_full = (count>=AF_THRESH), almost_empty = (count<=AE_THRESH).
REQ-024 SHALL set overflow on w_en & full, underflow on r_en & empty; remain set until clr_err=1 or reset; a set event in the same cycle as clr_err wins (flag stays 1).
REQ-025 SHALL leave memory, pointers and count unaltered by rejected requests.

Reset
REQ-026 SHALL on nrst=0 immediately force wr_ptr=0, rd_ptr=0, count=0, r_data=0, r_valid=0, overflow=0, underflow=0; hence empty=1, full=0, almost_empty=1, almost_full=0.
REQ-027 SHALL not reset memory contents; reset mid-operation discards all stored entries.

Structure
REQ-028 SHALL place shared constants/functions (address-width calculation, default thresholds) in package my_fifo_pkg.
REQ-029 SHALL instantiate one sub-module my_fifo_ram: simple dual-port array, one write port, one registered read port with enable, no reset.

Verification (WIDTH=8, DEPTH=8, AF_THRESH=6, AE_THRESH=2)
REQ-030 SHALL check: after reset, write 0x01..0x08 -> full=1 at count=8, almost_full from count=6; read 8 -> r_data 0x01..0x08 in order, each 1 cycle after r_en, empty=1 at end.
REQ-031 SHALL check: full FIFO, w_en=1 r_en=1 same cycle -> read accepted, write rejected, count=7, overflow=1.
REQ-032 SHALL check: empty FIFO, w_en=1 r_en=1 -> write accepted, read rejected, count=1, underflow=1, r_valid=0.
REQ-033 SHALL check: 20 writes/reads interleaved at count=4 -> pointers wrap twice, count stays 4, data order intact.
REQ-034 SHALL check: overflow set, clr_err pulse -> overflow=0 next cycle; clr_err coincident with w_en&full -> overflow stays 1.
REQ-035 SHALL check: nrst asserted at count=5 mid-write -> immediate count=0, empty=1, r_data=0; subsequent write/read returns new data only.
